// File: rtl/writeback_unit.sv
// Execute-to-writeback stage: commits ALU results into a 16-entry register file
// and the CNZV flag register, forwards operands/flags, and flushes after PC writes.
module writeback_unit #(
  parameter int WORD_WIDTH  = 32,
  parameter int REG_ADDR_W  = 4,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                  in_Clk,
  input  logic                  in_Reset,
  input  logic                  in_Valid,
  input  logic [WORD_WIDTH-1:0] in_Y,
  input  logic [3:0]            in_CNZV,
  input  logic                  in_Writeback,
  input  logic                  in_Set_cond,
  input  logic [REG_ADDR_W-1:0] in_Rd,
  input  logic [REG_ADDR_W-1:0] in_Rn_addr,
  input  logic [REG_ADDR_W-1:0] in_Rm_addr,
  output logic [WORD_WIDTH-1:0] out_Rn_data,
  output logic [WORD_WIDTH-1:0] out_Rm_data,
  output logic [3:0]            out_CNZV,
  output logic                  out_Branch,
  output logic [WORD_WIDTH-1:0] out_Branch_target,
  output logic                  out_Flushing,
  output logic [31:0]           out_Retired
);

  localparam int NumRegs = 1 << REG_ADDR_W;
  localparam int CntW    = $clog2(FLUSH_DEPTH + 1);
  localparam logic [REG_ADDR_W-1:0] PcAddr = '1;

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  state_t                r_state;
  logic [CntW-1:0]       r_flushCnt;
  logic [WORD_WIDTH-1:0] r_regs [NumRegs];
  logic [3:0]            r_flags;
  logic                  r_branch;
  logic [WORD_WIDTH-1:0] r_branchTarget;
  logic [31:0]           r_retired;

  logic w_commit;
  logic w_regWrite;
  logic w_flagWrite;
  logic w_pcWrite;

  // Results arriving while flushing are dropped entirely, so every side effect keys off w_commit.
  assign w_commit    = in_Valid && (r_state == RUN);
  assign w_regWrite  = w_commit && in_Writeback;
  assign w_flagWrite = w_commit && in_Set_cond;
  assign w_pcWrite   = w_regWrite && (in_Rd == PcAddr);

  assign out_Rn_data = (w_regWrite && (in_Rn_addr == in_Rd)) ? in_Y : r_regs[in_Rn_addr];
  assign out_Rm_data = (w_regWrite && (in_Rm_addr == in_Rd)) ? in_Y : r_regs[in_Rm_addr];
  assign out_CNZV    = w_flagWrite ? in_CNZV : r_flags;

  assign out_Branch        = r_branch;
  assign out_Branch_target = r_branchTarget;
  assign out_Flushing      = (r_state == FLUSH);
  assign out_Retired       = r_retired;

  always_ff @(posedge in_Clk) begin
    if (in_Reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        r_regs[i] <= '0;
      end
      r_flags        <= '0;
      r_branch       <= 1'b0;
      r_branchTarget <= '0;
      r_retired      <= '0;
      r_state        <= RUN;
      r_flushCnt     <= '0;
    end else begin
      r_branch <= w_pcWrite;
      if (w_regWrite) begin
        r_regs[in_Rd] <= in_Y;
      end
      if (w_flagWrite) begin
        r_flags <= in_CNZV;
      end
      if (w_commit) begin
        r_retired <= r_retired + 32'd1;
      end
      if (w_pcWrite) begin
        r_branchTarget <= in_Y;
      end

      case (r_state)
        RUN: begin
          if (w_pcWrite) begin
            r_state    <= FLUSH;
            r_flushCnt <= CntW'(FLUSH_DEPTH);
          end
        end
        FLUSH: begin
          // Leaving on the edge that discards the last result lets the next one commit.
          if (r_flushCnt <= CntW'(1)) begin
            if (in_Valid || (r_flushCnt == '0)) begin
              r_state    <= RUN;
              r_flushCnt <= '0;
            end
          end else if (in_Valid) begin
            r_flushCnt <= r_flushCnt - CntW'(1);
          end
        end
        default: begin
          r_state    <= RUN;
          r_flushCnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit: commit, bypass, flag update,
// PC-write branch/flush and reset-during-flush scenarios.
module tb_writeback_unit;

  logic        clk;
  logic        reset;
  logic        valid;
  logic [31:0] y;
  logic [3:0]  cnzv;
  logic        writeback;
  logic        setCond;
  logic [3:0]  rd;
  logic [3:0]  rnAddr;
  logic [3:0]  rmAddr;
  logic [31:0] rnData;
  logic [31:0] rmData;
  logic [3:0]  cnzvOut;
  logic        branch;
  logic [31:0] branchTarget;
  logic        flushing;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  writeback_unit #(
    .WORD_WIDTH (32),
    .REG_ADDR_W (4),
    .FLUSH_DEPTH(2)
  ) dut (
    .in_Clk           (clk),
    .in_Reset         (reset),
    .in_Valid         (valid),
    .in_Y             (y),
    .in_CNZV          (cnzv),
    .in_Writeback     (writeback),
    .in_Set_cond      (setCond),
    .in_Rd            (rd),
    .in_Rn_addr       (rnAddr),
    .in_Rm_addr       (rmAddr),
    .out_Rn_data      (rnData),
    .out_Rm_data      (rmData),
    .out_CNZV         (cnzvOut),
    .out_Branch       (branch),
    .out_Branch_target(branchTarget),
    .out_Flushing     (flushing),
    .out_Retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] yIn, input logic [3:0] flags,
                               input logic wb, input logic sc, input logic [3:0] rdIn);
    valid     = v;
    y         = yIn;
    cnzv      = flags;
    writeback = wb;
    setCond   = sc;
    rd        = rdIn;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic readRegs(input logic [3:0] a, input logic [3:0] b);
    rnAddr = a;
    rmAddr = b;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    valid = 1'b0; y = '0; cnzv = '0; writeback = 1'b0; setCond = 1'b0;
    rd = '0; rnAddr = '0; rmAddr = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state: every register, flags, counters.
    for (int i = 0; i < 16; i++) begin
      readRegs(4'(i), 4'(15 - i));
      checkOutput($sformatf("reset_rn_r%0d", i), rnData, 32'h0);
      checkOutput($sformatf("reset_rm_r%0d", 15 - i), rmData, 32'h0);
    end
    checkOutput("reset_cnzv", {28'h0, cnzvOut}, 32'h0);
    checkOutput("reset_retired", retired, 32'h0);
    checkOutput("reset_branch", {31'h0, branch}, 32'h0);
    checkOutput("reset_flushing", {31'h0, flushing}, 32'h0);

    // Commit Y=5 to R3 with flags 0010; both ports bypass in the same cycle.
    readRegs(4'd3, 4'd3);
    applyStimulus(1'b1, 32'd5, 4'b0010, 1'b1, 1'b1, 4'd3);
    checkOutput("bypass_rn", rnData, 32'd5);
    checkOutput("bypass_rm", rmData, 32'd5);
    checkOutput("bypass_cnzv", {28'h0, cnzvOut}, 32'h2);
    checkOutput("pre_commit_retired", retired, 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'd0);
    checkOutput("r3_written", rnData, 32'd5);
    checkOutput("flags_written", {28'h0, cnzvOut}, 32'h2);
    checkOutput("retired_1", retired, 32'd1);

    // Flag-only commit, then a commit with Set_cond low must not touch flags.
    applyStimulus(1'b1, 32'hDEAD, 4'b1000, 1'b0, 1'b1, 4'd3);
    checkOutput("no_wb_no_bypass", rnData, 32'd5);
    checkOutput("flag_only_bypass", {28'h0, cnzvOut}, 32'h8);
    tick();
    applyStimulus(1'b1, 32'hBEEF, 4'b0101, 1'b0, 1'b0, 4'd3);
    checkOutput("setcond0_no_bypass", {28'h0, cnzvOut}, 32'h8);
    tick();
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'd0);
    checkOutput("r3_unchanged", rnData, 32'd5);
    checkOutput("flags_kept", {28'h0, cnzvOut}, 32'h8);
    checkOutput("retired_3", retired, 32'd3);

    // PC write: branch pulse next cycle, then two results discarded.
    applyStimulus(1'b1, 32'h100, 4'b0000, 1'b1, 1'b0, 4'd15);
    checkOutput("branch_before_edge", {31'h0, branch}, 32'h0);
    tick();
    readRegs(4'd1, 4'd15);
    applyStimulus(1'b1, 32'd7, 4'b0000, 1'b1, 1'b0, 4'd1);
    checkOutput("branch_pulse", {31'h0, branch}, 32'h1);
    checkOutput("branch_target", branchTarget, 32'h100);
    checkOutput("flushing_1", {31'h0, flushing}, 32'h1);
    checkOutput("flush_no_bypass_r1", rnData, 32'h0);
    checkOutput("r15_written", rmData, 32'h100);
    tick();
    readRegs(4'd2, 4'd1);
    applyStimulus(1'b1, 32'd9, 4'b0001, 1'b1, 1'b1, 4'd2);
    checkOutput("branch_one_cycle", {31'h0, branch}, 32'h0);
    checkOutput("flushing_2", {31'h0, flushing}, 32'h1);
    checkOutput("flush_no_flag_bypass", {28'h0, cnzvOut}, 32'h8);
    checkOutput("flush_no_bypass_r2", rnData, 32'h0);
    checkOutput("r1_discarded", rmData, 32'h0);
    tick();
    readRegs(4'd4, 4'd2);
    applyStimulus(1'b1, 32'h33, 4'b0000, 1'b1, 1'b0, 4'd4);
    checkOutput("run_after_flush", {31'h0, flushing}, 32'h0);
    checkOutput("third_bypass", rnData, 32'h33);
    tick();
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'd0);
    checkOutput("r4_committed", rnData, 32'h33);
    checkOutput("r2_discarded", rmData, 32'h0);
    checkOutput("flags_after_flush", {28'h0, cnzvOut}, 32'h8);
    checkOutput("retired_5", retired, 32'd5);

    // Flush with idle cycles interleaved: only valid cycles advance the counter.
    applyStimulus(1'b1, 32'h200, 4'b0000, 1'b1, 1'b0, 4'd15);
    tick();
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'd0);
    tick();
    checkOutput("idle_flush_a", {31'h0, flushing}, 32'h1);
    applyStimulus(1'b1, 32'h11, 4'b0000, 1'b1, 1'b0, 4'd5);
    tick();
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'd0);
    tick();
    checkOutput("idle_flush_b", {31'h0, flushing}, 32'h1);
    applyStimulus(1'b1, 32'h22, 4'b0000, 1'b1, 1'b0, 4'd6);
    tick();
    readRegs(4'd5, 4'd6);
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'd0);
    checkOutput("idle_flush_done", {31'h0, flushing}, 32'h0);
    checkOutput("r5_discarded", rnData, 32'h0);
    checkOutput("r6_discarded", rmData, 32'h0);
    checkOutput("retired_6", retired, 32'd6);
    applyStimulus(1'b1, 32'h44, 4'b0000, 1'b1, 1'b0, 4'd5);
    tick();
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'd0);
    checkOutput("r5_committed", rnData, 32'h44);
    checkOutput("retired_7", retired, 32'd7);

    // Reset asserted mid-flush with a valid result pending.
    applyStimulus(1'b1, 32'h300, 4'b0000, 1'b1, 1'b0, 4'd15);
    tick();
    reset = 1'b1;
    applyStimulus(1'b1, 32'h55, 4'b0000, 1'b1, 1'b0, 4'd4);
    tick();
    reset = 1'b0;
    readRegs(4'd4, 4'd15);
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'd0);
    checkOutput("rst_r4", rnData, 32'h0);
    checkOutput("rst_r15", rmData, 32'h0);
    checkOutput("rst_flushing", {31'h0, flushing}, 32'h0);
    checkOutput("rst_branch", {31'h0, branch}, 32'h0);
    checkOutput("rst_target", branchTarget, 32'h0);
    checkOutput("rst_retired", retired, 32'h0);
    checkOutput("rst_cnzv", {28'h0, cnzvOut}, 32'h0);
    applyStimulus(1'b1, 32'h66, 4'b0000, 1'b1, 1'b0, 4'd4);
    tick();
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'd0);
    checkOutput("rst_run_commit", rnData, 32'h66);
    checkOutput("rst_retired_1", retired, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Execute-to-writeback stage sitting directly downstream of the ALU.
- Commits ALU results (out_Y, out_CNZV, out_Writeback) into the 16-entry register file and the CNZV flag register.
- Feeds register operands and current flags back to operand fetch / the ALU, with same-cycle forwarding.
- Handles writes to R15 (PC) by raising a branch pulse and flushing the two in-flight results that follow.

Parameters:
- WORD_WIDTH, `WordWidth (32): data width of registers and results.
- REG_ADDR_W, 4: register address width (16 registers; R15 is the PC).
- FLUSH_DEPTH, 2: number of results discarded after a PC write.

Ports:
- in_Clk  input  1  clock; all state updates on rising edge.
- in_Reset  input  1  synchronous reset, active-high.
- in_Valid  input  1  ALU result on in_Y/in_CNZV is valid this cycle.
- in_Y  input  WORD_WIDTH  ALU result.
- in_CNZV  input  4  ALU flag result, bit order {C,N,Z,V}.
- in_Writeback  input  1  result writes a register.
- in_Set_cond  input  1  result updates the flag register.
- in_Rd  input  REG_ADDR_W  destination register.
- in_Rn_addr  input  REG_ADDR_W  read port A address.
- in_Rm_addr  input  REG_ADDR_W  read port B address.
- out_Rn_data  output  WORD_WIDTH  read port A data, combinational.
- out_Rm_data  output  WORD_WIDTH  read port B data, combinational.
- out_CNZV  output  4  forwarded flags to the ALU in_CNZV.
- out_Branch  output  1  one-cycle pulse: PC was written.
- out_Branch_target  output  WORD_WIDTH  committed PC value; valid while out_Branch is high.
- out_Flushing  output  1  high while results are being discarded.
- out_Retired  output  32  count of committed results; wraps at 2^32.

Behaviour:
- Reset (in_Reset high at a clock edge):
  - all registers R0–R15 become 0; flags become 0000.
  - out_Branch = 0, out_Branch_target = 0, out_Retired = 0.
  - state goes to RUN; flush counter becomes 0.
  - Reset overrides every simultaneous event, including a mid-flush state.
- Commit:
  - A result commits when in_Valid=1 and state is RUN.
  - Committed results are discarded in FLUSH.
- Register write: commit & in_Writeback → reg[in_Rd] <= in_Y at the clock edge. Write latency is 1 cycle.
- Flag write: commit & in_Set_cond → flags <= in_CNZV. This is independent of in_Writeback, and both may occur together.
- Retire counter: out_Retired increments by 1 on every commit, regardless of Writeback/Set_cond.
- Read ports are combinational:
  - If commit & in_Writeback & addr==in_Rd, return in_Y (bypass).
  - Otherwise return reg[addr].
  - Both ports may bypass simultaneously.
- out_CNZV:
  - commit & in_Set_cond → in_CNZV (bypass).
  - Otherwise the registered flags.
  - In FLUSH, no bypass is applied.
- PC write (commit & in_Writeback & in_Rd==15):
  - next cycle out_Branch=1 and out_Branch_target=in_Y.
  - R15 is also written.
  - state → FLUSH with counter = FLUSH_DEPTH.
- State machine:
  - RUN: commits normally. A PC write moves to FLUSH.
  - FLUSH:
    - out_Flushing=1.
    - Each cycle with in_Valid=1 decrements the counter and discards the result: no register write, no flag write, no retire increment, no bypass.
    - Cycles with in_Valid=0 do not decrement.
    - Counter reaching 0 → RUN on the following edge.
    - A PC-write result arriving in FLUSH is discarded and raises no branch.
- out_Branch stays high for exactly one cycle per PC write and is low otherwise.
- No stall or backpressure: every valid result is consumed in its cycle.
- All arithmetic is unsigned. The counter wraps 0xFFFFFFFF → 0.

Test Plan:
- Reset, then read R0..R15 with in_Valid=0 → all reads 0, out_CNZV=0000, out_Retired=0.
- Commit Y=5, Rd=3, Writeback=1, Set_cond=1, CNZV=0010 → out_Rn_data=5 same cycle with Rn_addr=3 (bypass); next cycle reg R3=5, out_CNZV=0010, out_Retired=1.
- Commit Writeback=0, Set_cond=1, CNZV=1000, Rd=3 → R3 unchanged at 5, flags=1000; then Set_cond=0 with CNZV=0101 → flags remain 1000.
- Commit Y=0x100, Rd=15 → next cycle out_Branch=1 with target 0x100, then low. Next two valid results (Y=7→R1, Y=9→R2 with Set_cond) are discarded: R1, R2 and flags unchanged, out_Retired unchanged, out_Flushing=1 for those cycles. The third result commits.
- FLUSH with interleaved in_Valid=0 cycles → the counter only advances on valid cycles; RUN resumes after exactly 2 discarded results.
- Assert in_Reset during FLUSH with in_Valid=1, Rd=4 → R4=0, state RUN, out_Flushing=0, out_Branch=0 on the next cycle.
